// File: rtl/spi_xfer_ctrl.sv
//-----------------------------------------------------------------------------
// spi_xfer_ctrl
//
// Transfer sequencer that sits directly in front of an SPI master. Host words
// are queued in a TX FIFO; each word launches one master transfer with a
// single-cycle enable pulse. Completion is detected from the rising edge of
// the master's chip-select, and the word the master received is captured
// into an RX FIFO that the host drains through a valid/ready port.
//
// Optional feature macro: INTER_GAP_EN
//   defined   : after each completion the sequencer idles in GAP for
//               GAP_CYCLES clocks (minimum CS-high time between transfers).
//   undefined : GAP state and its counter do not exist; the next launch may
//               follow two cycles after completion.
//
// Parameters
//   DATA_WIDTH : word width, equal to the master's data width
//   FIFO_DEPTH : entries per FIFO (power of two, >= 2)
//   GAP_CYCLES : idle cycles between transfers (INTER_GAP_EN builds only)
//
// Ports
//   clk_i          system clock, rising edge
//   reset_ni       asynchronous active-low reset
//   tx_valid_i     host offers tx_data_i
//   tx_ready_o     TX FIFO not full
//   tx_data_i      word to shift out
//   rx_valid_o     RX FIFO not empty
//   rx_ready_i     host accepts rx_data_o
//   rx_data_o      registered RX FIFO head
//   busy_o         transfer in flight or TX FIFO non-empty
//   m_enable_o     one-cycle launch pulse to the master
//   m_data_in_o    word presented to the master's bus_data_in
//   m_data_out_i   word received by the master (bus_data_out)
//   m_cs_i         master chip-select, monitored only
//-----------------------------------------------------------------------------
module spi_xfer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
`ifdef INTER_GAP_EN
  ,
  parameter int GAP_CYCLES = 4
`endif
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  output logic                  m_enable_o,
  output logic [DATA_WIDTH-1:0] m_data_in_o,
  input  logic [DATA_WIDTH-1:0] m_data_out_i,
  input  logic                  m_cs_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LAUNCH     = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
`ifdef INTER_GAP_EN
  localparam logic [2:0] ST_GAP        = 3'd4;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
`endif

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0]         rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                  tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

  // Registered host-side flags and RX head
  logic                  tx_ready_q, tx_ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;

  // Sequencer
  logic [2:0]            state_q, state_d;
  logic                  m_enable_q, m_enable_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  cs_q;
`ifdef INTER_GAP_EN
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
`endif

  // Sequencer next-state: launch, wait for CS low, wait for CS rise, capture.
  always_comb begin
    state_d    = state_q;
    m_enable_d = 1'b0;
    m_data_d   = m_data_q;
    tx_pop_s   = 1'b0;
    rx_push_s  = 1'b0;
`ifdef INTER_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // RX space is reserved up front so the returned word always has a slot.
        if ((tx_cnt_q != CNT_ZERO) && (rx_cnt_q != CNT_FULL)) begin
          state_d    = ST_LAUNCH;
          m_enable_d = 1'b1;
          m_data_d   = tx_mem_q[tx_rd_q];
          tx_pop_s   = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!m_cs_i) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        // CS rising edge: the master's received word is valid this cycle.
        if (m_cs_i && !cs_q) begin
          rx_push_s = 1'b1;
`ifdef INTER_GAP_EN
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
`else
          state_d   = ST_IDLE;
`endif
        end else begin
          state_d   = ST_WAIT_DONE;
        end
      end
`ifdef INTER_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == GAP_ZERO) begin
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer/count updates, registered head and host-side flags.
  always_comb begin
    tx_push_s = tx_valid_i & tx_ready_q;
    rx_pop_s  = rx_valid_q & rx_ready_i;

    tx_wr_d = tx_push_s ? (tx_wr_q + PTR_ONE) : tx_wr_q;
    tx_rd_d = tx_pop_s  ? (tx_rd_q + PTR_ONE) : tx_rd_q;
    rx_wr_d = rx_push_s ? (rx_wr_q + PTR_ONE) : rx_wr_q;
    rx_rd_d = rx_pop_s  ? (rx_rd_q + PTR_ONE) : rx_rd_q;

    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase

    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    // The new head is the word being written only when it lands in the slot
    // the read pointer is about to point at (FIFO empty after any pop).
    if (rx_cnt_d == CNT_ZERO) begin
      rx_data_d = rx_data_q;
    end else if (rx_push_s && (rx_wr_q == rx_rd_d)) begin
      rx_data_d = m_data_out_i;
    end else begin
      rx_data_d = rx_mem_q[rx_rd_d];
    end

    tx_ready_d = (tx_cnt_d != CNT_FULL);
    rx_valid_d = (rx_cnt_d != CNT_ZERO);
    busy_d     = (state_d != ST_IDLE) || (tx_cnt_d != CNT_ZERO);
  end

  // FIFO storage writes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= DATA_ZERO;
        rx_mem_q[i] <= DATA_ZERO;
      end
    end else begin
      if (tx_push_s) begin
        tx_mem_q[tx_wr_q] <= tx_data_i;
      end
      if (rx_push_s) begin
        rx_mem_q[rx_wr_q] <= m_data_out_i;
      end
    end
  end

  // FIFO pointers, counts, registered head and host-side flags.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_wr_q    <= {AW{1'b0}};
      tx_rd_q    <= {AW{1'b0}};
      rx_wr_q    <= {AW{1'b0}};
      rx_rd_q    <= {AW{1'b0}};
      tx_cnt_q   <= CNT_ZERO;
      rx_cnt_q   <= CNT_ZERO;
      rx_data_q  <= DATA_ZERO;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Sequencer state, master-facing registers and CS history.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      m_enable_q <= 1'b0;
      m_data_q   <= DATA_ZERO;
      cs_q       <= 1'b1;
`ifdef INTER_GAP_EN
      gap_cnt_q  <= GAP_ZERO;
`endif
    end else begin
      state_q    <= state_d;
      m_enable_q <= m_enable_d;
      m_data_q   <= m_data_d;
      cs_q       <= m_cs_i;
`ifdef INTER_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign tx_ready_o  = tx_ready_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign busy_o      = busy_q;
  assign m_enable_o  = m_enable_q;
  assign m_data_in_o = m_data_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
//-----------------------------------------------------------------------------
// tb_spi_xfer_ctrl
//
// Directed bench for spi_xfer_ctrl. A behavioural SPI master answers each
// enable pulse by pulling CS low for three cycles and returning the launched
// word XOR 8'h99 when CS rises. A negedge monitor logs enable pulses, CS
// rises and RX handshakes with cycle stamps.
//-----------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef INTER_GAP_EN
  localparam int SPACING = 6;
`else
  localparam int SPACING = 2;
`endif

  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] exp_launch;
    logic [7:0] exp_rx;
  } xfer_vec_t;

  logic          clk, rst_n;
  logic          tx_valid, tx_ready, rx_valid, rx_ready, busy, m_enable, m_cs;
  logic [DW-1:0] tx_data, rx_data, m_data_in, m_data_out;

  spi_xfer_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_data_i    (tx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .rx_data_o    (rx_data),
    .busy_o       (busy),
    .m_enable_o   (m_enable),
    .m_data_in_o  (m_data_in),
    .m_data_out_i (m_data_out),
    .m_cs_i       (m_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vec_cnt    = 0;
  int         miscmp_cnt = 0;
  int         cyc        = 0;
  int         dbl_en     = 0;
  logic       prev_en    = 1'b0;
  logic       prev_cs    = 1'b1;
  logic [7:0] en_q[$];
  int         en_cyc[$];
  int         rise_cyc[$];
  logic [7:0] rx_q[$];

  xfer_vec_t  burst_tab [4];
  logic [7:0] drain_tab [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] at8(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? {24'h000000, q[i]} : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] at32(input int q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEADBEEF;
  endfunction

  // Negedge monitor: enable pulses, CS rises, RX handshakes.
  always @(negedge clk) begin
    cyc++;
    if (m_enable) begin
      en_q.push_back(m_data_in);
      en_cyc.push_back(cyc);
    end
    if (m_enable && prev_en) dbl_en++;
    if (m_cs && !prev_cs) rise_cyc.push_back(cyc);
    if (rx_valid && rx_ready) rx_q.push_back(rx_data);
    prev_en = m_enable;
    prev_cs = m_cs;
  end

  // Behavioural SPI master (also reset by rst_n).
  int         mphase = 0;
  int         mcnt   = 0;
  logic [7:0] mword  = 8'h00;
  logic       s_en;
  logic [7:0] s_d;
  bit         pop_on_done = 1'b0;
  bit         drop_rdy    = 1'b0;

  always begin
    @(posedge clk);
    s_en = m_enable;
    s_d  = m_data_in;
    #1;
    if (drop_rdy) begin
      rx_ready = 1'b0;
      drop_rdy = 1'b0;
    end
    if (!rst_n) begin
      m_cs   = 1'b1;
      mphase = 0;
    end else begin
      case (mphase)
        0: if (s_en) begin mword = s_d; mphase = 1; end
        1: begin m_cs = 1'b0; mcnt = 3; mphase = 2; end
        2: begin
          if (mcnt == 1) begin
            m_data_out = mword ^ 8'h99;
            m_cs       = 1'b1;
            mphase     = 0;
            if (pop_on_done) begin
              rx_ready    = 1'b1;
              drop_rdy    = 1'b1;
              pop_on_done = 1'b0;
            end
          end else begin
            mcnt--;
          end
        end
        default: mphase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    en_q.delete(); en_cyc.delete(); rise_cyc.delete(); rx_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    clear_q();
  endtask

  task automatic push(input logic [7:0] w);
    int k = 0;
    tx_valid = 1'b1;
    tx_data  = w;
    while (!tx_ready && k < 500) begin tick(); k++; end
    chk("push_accept", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] e);
    int k = 0;
    while (!rx_valid && k < 500) begin tick(); k++; end
    chk({nm, "_valid"}, rx_valid, 1);
    chk(nm, rx_data, e);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic wait_rises(input int n, input string nm);
    int k = 0;
    while (rise_cyc.size() < n && k < 2000) begin tick(); k++; end
    chk(nm, rise_cyc.size() >= n, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    burst_tab[0] = '{tx: 8'h01, exp_launch: 8'h01, exp_rx: 8'h98};
    burst_tab[1] = '{tx: 8'h02, exp_launch: 8'h02, exp_rx: 8'h9B};
    burst_tab[2] = '{tx: 8'h03, exp_launch: 8'h03, exp_rx: 8'h9A};
    burst_tab[3] = '{tx: 8'h04, exp_launch: 8'h04, exp_rx: 8'h9D};
    drain_tab[0] = 8'h88; drain_tab[1] = 8'h8B; drain_tab[2] = 8'h8A; drain_tab[3] = 8'h8D;
    drain_tab[4] = 8'h8C; drain_tab[5] = 8'h8F; drain_tab[6] = 8'h8E; drain_tab[7] = 8'h81;

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    m_cs = 1'b1; m_data_out = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_enable", m_enable, 0);
    chk("rst_m_data_in", m_data_in, 8'h00);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    clear_q();

    // Single word
    push(8'hA5);
    wait_rises(1, "single_done");
    chk("single_en_count", en_q.size(), 1);
    chk("single_m_data_in", at8(en_q, 0), 8'hA5);
    tick();
    chk("single_rx_valid", rx_valid, 1);
    chk("single_rx_data", rx_data, 8'h3C);
    chk("single_busy", busy, 0);
    chk("single_m_data_hold", m_data_in, 8'hA5);
    pop_chk("single_pop", 8'h3C);
    chk("single_rx_empty", rx_valid, 0);

    // Burst of four, table driven
    do_reset();
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1;
      tx_data  = burst_tab[i].tx;
      chk("burst_tx_ready", tx_ready, 1);
      tick();
    end
    tx_valid = 1'b0;
    wait_rises(4, "burst_done");
    repeat (3) tick();
    rx_ready = 1'b0;
    chk("burst_en_count", en_q.size(), 4);
    chk("burst_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_launch_data", at8(en_q, i), {24'h000000, burst_tab[i].exp_launch});
      chk("burst_rx_data", at8(rx_q, i), {24'h000000, burst_tab[i].exp_rx});
      if (i < 3) chk("burst_spacing", at32(en_cyc, i + 1) - at32(rise_cyc, i), SPACING);
    end
    chk("burst_busy_end", busy, 0);

    // RX backpressure: six words, RX depth four
    do_reset();
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    wait_rises(4, "bp_done4");
    repeat (10) tick();
    chk("bp_en_count", en_q.size(), 4);
    chk("bp_busy_stall", busy, 1);
    chk("bp_tx_ready", tx_ready, 1);
    chk("bp_rx_head", rx_data, 8'h89);
    // One RX pop; TX push coincides with the resulting launch pop.
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0; tx_valid = 1'b1; tx_data = 8'h16;
    tick();
    tx_data = 8'h17;
    chk("txpp_ready_cnt2", tx_ready, 1);
    tick();
    tx_data = 8'h18;
    chk("txpp_ready_cnt3", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
    chk("txpp_ready_full", tx_ready, 0);
    repeat (20) tick();
    chk("bp_pop_rx", at8(rx_q, 0), 8'h89);
    chk("bp_en_count_after_pop", en_q.size(), 5);
    chk("bp_fifth_launch", at8(en_q, 4), 8'h14);
    chk("bp_tx_still_full", tx_ready, 0);
    for (int i = 0; i < 8; i++) pop_chk("bp_drain", drain_tab[i]);
    k = 0;
    while (busy && k < 500) begin tick(); k++; end
    chk("bp_busy_end", busy, 0);

    // RX at depth-1 with a pop in the completion cycle
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    wait_rises(3, "full1_done3");
    pop_on_done = 1'b1;
    wait_rises(4, "full1_done4");
    repeat (2) tick();
    chk("full1_pop_count", rx_q.size(), 1);
    chk("full1_pop_data", at8(rx_q, 0), 8'hB8);
    pop_chk("full1_rx1", 8'hBB);
    pop_chk("full1_rx2", 8'hBA);
    pop_chk("full1_rx3", 8'hBD);
    chk("full1_rx_empty", rx_valid, 0);

    // Reset during WAIT_DONE
    do_reset();
    push(8'h5A);
    k = 0;
    while (m_cs && k < 100) begin tick(); k++; end
    chk("rst_mid_cs_low", m_cs, 0);
    tick();
    chk("rst_mid_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_m_enable", m_enable, 0);
    chk("rst_mid_rx_valid", rx_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_tx_ready", tx_ready, 1);
    clear_q();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) tick();
    chk("rst_mid_no_launch", en_q.size(), 0);
    chk("rst_mid_rx_after", rx_valid, 0);
    chk("rst_mid_busy_after", busy, 0);

    chk("m_enable_single_cycle", dbl_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- Transfer sequencer directly upstream of the SPI master.
- Buffers host words in a TX FIFO and launches one master transfer per word with a single-cycle enable pulse.
- Detects transfer completion from the master's chip-select and captures the master's received word into an RX FIFO.
- Gives the host a valid/ready streaming interface in place of the master's raw enable/bus_data pins.

Parameters:
- data_width, 8, word width; must equal the master's data_width.
- fifo_depth, 4, entries per FIFO; power of two, >= 2.
- gap_cycles, 4, idle clk cycles between transfers; used only with INTER_GAP_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_valid  in  1  host offers tx_data.
- tx_ready  out  1  TX FIFO not full.
- tx_data  in  data_width  word to shift out.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  host accepts rx_data.
- rx_data  out  data_width  RX FIFO head.
- busy  out  1  transfer in flight or TX FIFO non-empty.
- m_enable  out  1  to master enable; one-cycle pulse.
- m_data_in  out  data_width  to master bus_data_in.
- m_data_out  in  data_width  from master bus_data_out.
- m_cs  in  1  from master spi_cs (monitor only).

Behaviour:
- Reset (reset=0, asynchronous):
  - Both FIFOs empty.
  - Outputs: m_enable=0, m_data_in=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0.
  - State=IDLE. cs_q (registered copy of m_cs) set to 1.
- FIFO handshake:
  - TX push on tx_valid&&tx_ready. RX pop on rx_valid&&rx_ready.
  - rx_data is a registered head; it is valid whenever rx_valid=1.
  - Push and pop in the same cycle are legal on either FIFO; count is unchanged.
  - Push to a full FIFO cannot occur because the ready/valid gating blocks it.
  - No bypass: a word pushed in cycle N is launchable at the earliest in cycle N+1.
  - Pointers wrap modulo fifo_depth. Counts use log2(fifo_depth)+1 bits.
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE, and GAP (present only with the feature).
  - IDLE: when TX is non-empty AND RX count < fifo_depth, go to LAUNCH. On that edge:
    - Register m_data_in = TX head.
    - Pop TX.
    - Register m_enable=1.
    - The RX space check guarantees every received word has a slot; RX never overflows.
  - LAUNCH (1 cycle): m_enable=1 is visible to the master this cycle. Next state is WAIT_START with m_enable=0.
    - m_data_in holds its value until the next launch.
  - WAIT_START: wait for m_cs==0, then go to WAIT_DONE.
  - WAIT_DONE: completion is the cycle where m_cs==1 && cs_q==0 (rising edge). In that same cycle:
    - m_data_out holds the master's received word.
    - Push m_data_out into RX.
    - Go to IDLE (or to GAP).
  - From IDLE the next m_enable appears 2 cycles after completion. The master is back in idle by then.
- m_enable is never high for more than one consecutive cycle, and never high outside LAUNCH.
- busy = (state!=IDLE) || TX non-empty.
- An RX push and an RX pop in the completion cycle are both honoured.
- Reset asserted mid-transfer:
  - Everything returns to reset values immediately.
  - The pending received word is discarded.
  - The master is reset by the same system reset.

Optional Feature:
- INTER_GAP_EN defined:
  - WAIT_DONE goes to GAP instead of IDLE.
  - GAP holds for gap_cycles clk cycles with m_enable=0 and busy=1, then goes to IDLE.
  - This guarantees minimum CS-high time between transfers.
- Undefined: the GAP state and its counter are absent; WAIT_DONE goes straight to IDLE.

Test Plan:
- Single word: push 0xA5 with the master/slave model returning 0x3C.
  - Exactly one m_enable pulse with m_data_in=0xA5.
  - rx_data=0x3C, rx_valid=1 two cycles after the m_cs rise.
  - busy falls afterwards.
- Burst: push 0x01,0x02,0x03,0x04 back-to-back with rx_ready=1.
  - tx_ready stays 1.
  - Four transfers run in order; RX yields the echoes in order.
  - Enable pulses are spaced exactly 2 cycles after each completion.
- RX backpressure: rx_ready=0 and push 6 words with fifo_depth=4.
  - Exactly 4 transfers run, then the controller stalls in IDLE with busy=1.
  - tx_ready returns to 1 after the launches free TX entries.
  - Popping one RX word triggers exactly one further launch.
- Simultaneous events:
  - RX full-1 with a pop in the completion cycle: count stays fifo_depth-1 and the data order is preserved.
  - TX push and pop in the same cycle: count is unchanged.
- Reset mid-transfer: assert reset during WAIT_DONE.
  - m_enable=0, rx_valid=0, busy=0 immediately.
  - After release the controller stays in IDLE with no launch.
- INTER_GAP_EN with gap_cycles=4, two words queued: the second m_enable occurs exactly 6 cycles after the first completion edge.
